// File: rtl/zsdram_client_responder_pkg.sv
// Shared definitions for the SDRAM client responder: FSM encoding, burst
// geometry and the frame-buffer / pulse-counter address map.
package zsdram_client_responder_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CMD     = 3'd1,
        ST_WR_BEAT = 3'd2,
        ST_RD_BEAT = 3'd3,
        ST_DONE    = 3'd4,
        ST_RELEASE = 3'd5
    } state_e;

    localparam int SDRAM_BURST_LEN = 4;
    localparam int SDRAM_ADDR_W    = 24;  // bank(2) + row(13) + column(9)
    localparam int SDRAM_DATA_W    = 16;

    // Address map: graphics RAM followed by the pulse-counter ring buffer.
    localparam int GRAM_BASE      = 0;
    localparam int GRAM_END       = 383999;
    localparam int RING_BASE      = 384000;
    localparam int RING_LAST_SLOT = 386396;

endpackage

// File: rtl/zsdram_beat_cnt.sv
// Two-bit beat counter shared by write and read bursts. Advances once per
// accepted beat and flags the final beat of the burst; the increment that
// accepts the final beat wraps it back to 0 as the FSM leaves the beat state.
module zsdram_beat_cnt
    import zsdram_client_responder_pkg::*;
#(
    parameter int LAST_BEAT = SDRAM_BURST_LEN - 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       inc,
    output logic [1:0] beat,
    output logic       last
);

    logic [1:0] cnt_q;
    logic [1:0] cnt_d;

    // Next count: hold, clear while idle, or advance on an accepted beat.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = 2'd0;
        end else if (inc) begin
            cnt_d = cnt_q + 2'd1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 2'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign beat = cnt_q;
    assign last = (cnt_q == 2'(LAST_BEAT));

endmodule

// File: rtl/zsdram_client_responder.sv
// Adapts a level-request, four-word client port to a native burst SDRAM
// controller (command handshake plus per-beat data strobes).
// Optional feature: define ZSDRAM_ALIGN_CHECK_EN to reject addresses that are
// not 4-word aligned (oAlign_Err + Done, no memory command). Without it the
// low two address bits are simply cleared.
module zsdram_client_responder
    import zsdram_client_responder_pkg::*;
#(
    parameter int BURST_LEN = SDRAM_BURST_LEN,
    parameter int ADDR_W    = SDRAM_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              iSDRAM_Rd_Req,
    input  logic [ADDR_W-1:0] iSDRAM_Rd_Addr,
    output logic [15:0]       oSDRAM_Data1,
    output logic [15:0]       oSDRAM_Data2,
    output logic [15:0]       oSDRAM_Data3,
    output logic [15:0]       oSDRAM_Data4,
    output logic              oSDRAM_Rd_Done,
    input  logic              iSDRAM_Wr_Req,
    input  logic [ADDR_W-1:0] iSDRAM_Wr_Addr,
    input  logic [15:0]       iSDRAM_Wr_Data1,
    input  logic [15:0]       iSDRAM_Wr_Data2,
    input  logic [15:0]       iSDRAM_Wr_Data3,
    input  logic [15:0]       iSDRAM_Wr_Data4,
    output logic              oSDRAM_Wr_Done,
    output logic              oMem_Cmd_Valid,
    input  logic              iMem_Cmd_Ready,
    output logic              oMem_Cmd_Wr,
    output logic [ADDR_W-1:0] oMem_Addr,
    input  logic              iMem_Wr_Data_Req,
    output logic [15:0]       oMem_Wr_Data,
    input  logic              iMem_Rd_Valid,
    input  logic [15:0]       iMem_Rd_Data,
    output logic              oAlign_Err
);

    state_e            state_q, state_d;
    logic              dir_wr_q, dir_wr_d;      // direction of the burst in flight
    logic              last_wr_q, last_wr_d;    // last-served flag, 0 = read
    logic              cmd_valid_q, cmd_valid_d;
    logic              rd_done_q, rd_done_d;
    logic              wr_done_q, wr_done_d;
    logic              align_err_q, align_err_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       wdata_q [4];
    logic [15:0]       wdata_d [4];
    logic [15:0]       rdata_q [4];
    logic [15:0]       rdata_d [4];

    logic              pick_wr;
    logic [ADDR_W-1:0] sel_addr;
    logic              misalign;
    logic [1:0]        beat;
    logic              last_beat;
    logic              beat_inc;
    logic              beat_clr;

    // Write wins when alone, or on a tie when the previous burst was a read.
    assign pick_wr  = iSDRAM_Wr_Req & (~iSDRAM_Rd_Req | ~last_wr_q);
    assign sel_addr = pick_wr ? iSDRAM_Wr_Addr : iSDRAM_Rd_Addr;

`ifdef ZSDRAM_ALIGN_CHECK_EN
    assign misalign = |sel_addr[1:0];
`else
    assign misalign = 1'b0;
`endif

    // Strobes only count while the matching beat state is active.
    assign beat_inc = ((state_q == ST_WR_BEAT) & iMem_Wr_Data_Req) |
                      ((state_q == ST_RD_BEAT) & iMem_Rd_Valid);
    assign beat_clr = (state_q == ST_IDLE);

    zsdram_beat_cnt #(
        .LAST_BEAT (BURST_LEN - 1)
    ) u_beat_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (beat_clr),
        .inc   (beat_inc),
        .beat  (beat),
        .last  (last_beat)
    );

    // Next-state and registered-output computation for the transfer FSM.
    always_comb begin
        state_d     = state_q;
        dir_wr_d    = dir_wr_q;
        last_wr_d   = last_wr_q;
        cmd_valid_d = cmd_valid_q;
        addr_d      = addr_q;
        rd_done_d   = 1'b0;
        wr_done_d   = 1'b0;
        align_err_d = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wdata_d[i] = wdata_q[i];
            rdata_d[i] = rdata_q[i];
        end

        case (state_q)
            ST_IDLE: begin
                if (iSDRAM_Wr_Req || iSDRAM_Rd_Req) begin
                    dir_wr_d  = pick_wr;
                    last_wr_d = pick_wr;
                    addr_d    = sel_addr & ~ADDR_W'(3);
                    if (pick_wr) begin
                        wdata_d[0] = iSDRAM_Wr_Data1;
                        wdata_d[1] = iSDRAM_Wr_Data2;
                        wdata_d[2] = iSDRAM_Wr_Data3;
                        wdata_d[3] = iSDRAM_Wr_Data4;
                    end
                    if (misalign) begin
                        state_d     = ST_DONE;
                        align_err_d = 1'b1;
                        wr_done_d   = pick_wr;
                        rd_done_d   = ~pick_wr;
                    end else begin
                        state_d     = ST_CMD;
                        cmd_valid_d = 1'b1;
                    end
                end
            end
            ST_CMD: begin
                if (iMem_Cmd_Ready) begin
                    cmd_valid_d = 1'b0;
                    state_d     = dir_wr_q ? ST_WR_BEAT : ST_RD_BEAT;
                end
            end
            ST_WR_BEAT: begin
                if (iMem_Wr_Data_Req && last_beat) begin
                    state_d   = ST_DONE;
                    wr_done_d = 1'b1;
                end
            end
            ST_RD_BEAT: begin
                if (iMem_Rd_Valid) begin
                    rdata_d[beat] = iMem_Rd_Data;
                    if (last_beat) begin
                        state_d   = ST_DONE;
                        rd_done_d = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_RELEASE;
            end
            ST_RELEASE: begin
                // A still-held request must be dropped before the next burst.
                if (dir_wr_q ? !iSDRAM_Wr_Req : !iSDRAM_Rd_Req) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM state and all registered outputs; reset aborts any burst silently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            dir_wr_q    <= 1'b0;
            last_wr_q   <= 1'b0;
            cmd_valid_q <= 1'b0;
            addr_q      <= '0;
            rd_done_q   <= 1'b0;
            wr_done_q   <= 1'b0;
            align_err_q <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                wdata_q[i] <= '0;
                rdata_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            dir_wr_q    <= dir_wr_d;
            last_wr_q   <= last_wr_d;
            cmd_valid_q <= cmd_valid_d;
            addr_q      <= addr_d;
            rd_done_q   <= rd_done_d;
            wr_done_q   <= wr_done_d;
            align_err_q <= align_err_d;
            for (int i = 0; i < 4; i++) begin
                wdata_q[i] <= wdata_d[i];
                rdata_q[i] <= rdata_d[i];
            end
        end
    end

    assign oMem_Cmd_Valid = cmd_valid_q;
    assign oMem_Cmd_Wr    = dir_wr_q;
    assign oMem_Addr      = addr_q;
    assign oMem_Wr_Data   = (state_q == ST_WR_BEAT) ? wdata_q[beat] : 16'h0000;
    assign oSDRAM_Rd_Done = rd_done_q;
    assign oSDRAM_Wr_Done = wr_done_q;
    assign oAlign_Err     = align_err_q;
    assign oSDRAM_Data1   = rdata_q[0];
    assign oSDRAM_Data2   = rdata_q[1];
    assign oSDRAM_Data3   = rdata_q[2];
    assign oSDRAM_Data4   = rdata_q[3];

endmodule

// File: tb/tb_zsdram_client_responder.sv
// Directed bench for zsdram_client_responder: write/read bursts, arbitration,
// held-request release, mid-burst reset and address alignment handling.
module tb_zsdram_client_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rd_req, wr_req;
    logic [23:0] rd_addr, wr_addr;
    logic [15:0] wd1, wd2, wd3, wd4;
    logic [15:0] d1, d2, d3, d4;
    logic        rd_done, wr_done;
    logic        cmd_valid, cmd_ready, cmd_wr;
    logic [23:0] mem_addr;
    logic        wr_data_req;
    logic [15:0] mem_wr_data;
    logic        rd_valid;
    logic [15:0] rd_data;
    logic        align_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    zsdram_client_responder dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .iSDRAM_Rd_Req    (rd_req),
        .iSDRAM_Rd_Addr   (rd_addr),
        .oSDRAM_Data1     (d1),
        .oSDRAM_Data2     (d2),
        .oSDRAM_Data3     (d3),
        .oSDRAM_Data4     (d4),
        .oSDRAM_Rd_Done   (rd_done),
        .iSDRAM_Wr_Req    (wr_req),
        .iSDRAM_Wr_Addr   (wr_addr),
        .iSDRAM_Wr_Data1  (wd1),
        .iSDRAM_Wr_Data2  (wd2),
        .iSDRAM_Wr_Data3  (wd3),
        .iSDRAM_Wr_Data4  (wd4),
        .oSDRAM_Wr_Done   (wr_done),
        .oMem_Cmd_Valid   (cmd_valid),
        .iMem_Cmd_Ready   (cmd_ready),
        .oMem_Cmd_Wr      (cmd_wr),
        .oMem_Addr        (mem_addr),
        .iMem_Wr_Data_Req (wr_data_req),
        .oMem_Wr_Data     (mem_wr_data),
        .iMem_Rd_Valid    (rd_valid),
        .iMem_Rd_Data     (rd_data),
        .oAlign_Err       (align_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Advance until a Done pulse is seen, bounded to 40 cycles.
    task automatic wait_done(output logic got_wr, output logic got_rd);
        int n;
        tick;
        n = 1;
        while (n < 40 && !(wr_done || rd_done)) begin
            tick;
            n++;
        end
        got_wr = wr_done;
        got_rd = rd_done;
        chk("done_seen", {31'b0, (wr_done | rd_done)}, 32'd1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_cmd_valid"}, {31'b0, cmd_valid}, 32'd0);
        chk({tag, "_mem_addr"}, {8'b0, mem_addr}, 32'd0);
        chk({tag, "_wr_data"}, {16'b0, mem_wr_data}, 32'd0);
        chk({tag, "_data"}, {d1 | d2 | d3 | d4, 16'b0}, 32'd0);
        chk({tag, "_dones"}, {30'b0, rd_done, wr_done}, 32'd0);
        chk({tag, "_align"}, {31'b0, align_err}, 32'd0);
    endtask

    initial begin
        logic        gw, gr;
        logic [15:0] rv [4];

        rst_n = 1'b0;
        rd_req = 0; wr_req = 0; rd_addr = '0; wr_addr = '0;
        wd1 = 0; wd2 = 0; wd3 = 0; wd4 = 0;
        cmd_ready = 0; wr_data_req = 0; rd_valid = 0; rd_data = 0;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst_n = 1'b1;
        tick;

        // Write burst to the ring-buffer base, all strobes immediate.
        cmd_ready = 1; wr_data_req = 1;
        wr_addr = 24'd384000;
        wd1 = 16'h1111; wd2 = 16'h2222; wd3 = 16'h3333; wd4 = 16'h4444;
        wr_req = 1;
        chk("wr_idle_valid", {31'b0, cmd_valid}, 32'd0);
        tick;
        chk("wr_cmd_valid", {31'b0, cmd_valid}, 32'd1);
        chk("wr_cmd_addr", {8'b0, mem_addr}, 32'd384000);
        chk("wr_cmd_dir", {31'b0, cmd_wr}, 32'd1);
        tick;
        chk("wr_valid_drop", {31'b0, cmd_valid}, 32'd0);
        chk("wr_beat0", {16'b0, mem_wr_data}, 32'h1111);
        tick;
        chk("wr_beat1", {16'b0, mem_wr_data}, 32'h2222);
        tick;
        chk("wr_beat2", {16'b0, mem_wr_data}, 32'h3333);
        tick;
        chk("wr_beat3", {16'b0, mem_wr_data}, 32'h4444);
        chk("wr_done_early", {31'b0, wr_done}, 32'd0);
        tick;
        chk("wr_done_cycle7", {30'b0, rd_done, wr_done}, 32'd1);
        tick;
        chk("wr_done_one_cycle", {31'b0, wr_done}, 32'd0);
        wr_req = 0; wr_data_req = 0;
        tick;

        // Read burst from the last ring slot, beats separated by idle cycles.
        rv[0] = 16'h00C8; rv[1] = 16'h0000; rv[2] = 16'h0000; rv[3] = 16'h0000;
        rd_addr = 24'd386396;
        rd_req = 1;
        tick;
        chk("rd_cmd_valid", {31'b0, cmd_valid}, 32'd1);
        chk("rd_cmd_addr", {8'b0, mem_addr}, 32'd386396);
        chk("rd_cmd_dir", {31'b0, cmd_wr}, 32'd0);
        tick;
        for (int i = 0; i < 4; i++) begin
            rd_valid = 1; rd_data = rv[i];
            tick;
            rd_valid = 0; rd_data = 16'hDEAD;
            chk("rd_done_at_beat", {31'b0, rd_done}, (i == 3) ? 32'd1 : 32'd0);
            if (i < 3) begin
                tick;
                chk("rd_done_gap", {31'b0, rd_done}, 32'd0);
            end
        end
        chk("rd_data1", {16'b0, d1}, 32'h00C8);
        chk("rd_data234", {d2 | d3 | d4, 16'b0}, 32'd0);
        tick;
        chk("rd_done_single", {31'b0, rd_done}, 32'd0);
        chk("rd_data1_stable", {16'b0, d1}, 32'h00C8);
        rd_req = 0;
        tick;
        tick;

        // Simultaneous requests alternate, write first.
        cmd_ready = 1; wr_data_req = 1; rd_valid = 1; rd_data = 16'h5A5A;
        wr_addr = 24'h000100; rd_addr = 24'h000200;
        for (int r = 0; r < 2; r++) begin
            wr_req = 1; rd_req = 1;
            wait_done(gw, gr);
            chk("arb_first_write", {30'b0, gw, gr}, 32'd2);
            wr_req = 0;
            wait_done(gw, gr);
            chk("arb_second_read", {30'b0, gw, gr}, 32'd1);
            rd_req = 0;
            tick;
            tick;
        end
        rd_valid = 0;

        // Held request must not start a second burst.
        wr_req = 1;
        wait_done(gw, gr);
        chk("held_first_done", {30'b0, gw, gr}, 32'd2);
        for (int i = 0; i < 5; i++) begin
            tick;
            chk("held_no_cmd", {31'b0, cmd_valid}, 32'd0);
        end
        wr_req = 0;
        tick;
        tick;
        chk("held_dropped_no_cmd", {31'b0, cmd_valid}, 32'd0);
        wr_req = 1;
        tick;
        chk("held_reraise_cmd", {31'b0, cmd_valid}, 32'd1);
        wait_done(gw, gr);
        wr_req = 0; wr_data_req = 0;
        tick;
        tick;

        // Reset in the middle of a read burst.
        rd_addr = 24'h000040;
        rd_req = 1;
        tick;
        tick;
        rd_valid = 1; rd_data = 16'hA001;
        tick;
        rd_data = 16'hA002;
        tick;
        rd_data = 16'hA003;
        tick;
        rd_valid = 0;
        chk("mid_rd_data1", {16'b0, d1}, 32'hA001);
        rd_req = 0;
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("midreset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick;
            chk("post_reset_quiet", {29'b0, cmd_valid, rd_done, wr_done}, 32'd0);
        end
        rd_addr = 24'h000080;
        rd_req = 1;
        tick;
        tick;
        for (int i = 0; i < 4; i++) begin
            rd_valid = 1; rd_data = 16'(i + 1);
            tick;
        end
        rd_valid = 0;
        chk("after_reset_done", {31'b0, rd_done}, 32'd1);
        chk("after_reset_data", {d1[7:0], d2[7:0], d3[7:0], d4[7:0]}, 32'h01020304);
        rd_req = 0;
        tick;
        tick;

        // Misaligned address 7213.
        rd_addr = 24'd7213;
        rd_req = 1;
        tick;
`ifdef ZSDRAM_ALIGN_CHECK_EN
        chk("align_err_pulse", {31'b0, align_err}, 32'd1);
        chk("align_done_pulse", {30'b0, rd_done, wr_done}, 32'd2);
        chk("align_no_cmd", {31'b0, cmd_valid}, 32'd0);
        chk("align_data_kept", {16'b0, d1}, 32'h0001);
        tick;
        chk("align_err_one_cycle", {31'b0, align_err}, 32'd0);
        chk("align_no_cmd_later", {31'b0, cmd_valid}, 32'd0);
`else
        chk("align_masked_addr", {8'b0, mem_addr}, 32'd7212);
        chk("align_cmd_issued", {31'b0, cmd_valid}, 32'd1);
        chk("align_err_tied", {31'b0, align_err}, 32'd0);
        tick;
        for (int i = 0; i < 4; i++) begin
            rd_valid = 1; rd_data = 16'h7777;
            tick;
        end
        rd_valid = 0;
        chk("align_masked_done", {31'b0, rd_done}, 32'd1);
        chk("align_masked_data", {16'b0, d1}, 32'h7777);
`endif
        rd_req = 0;
        tick;
        tick;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/zsdram_client_responder.md
ZSDRAM_CLIENT_RESPONDER -- requirements
Module: zsdram_client_responder

Interface
REQ-001 SHALL have parameter BURST_LEN, default 4, meaning words per client transfer (fixed 4; other values unsupported).
REQ-002 SHALL have parameter ADDR_W, default 24, meaning SDRAM address width: Bank(2)+Row(13)+Column(9).
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 iSDRAM_Rd_Req  input  1  client read request, level, held until Done seen.
REQ-006 iSDRAM_Rd_Addr  input  24  client read address, 4-word aligned.
REQ-007 oSDRAM_Data1..oSDRAM_Data4  output  16 each  read-back words, beat 0..3.
REQ-008 oSDRAM_Rd_Done  output  1  one-cycle read completion pulse.
REQ-009 iSDRAM_Wr_Req  input  1  client write request, level.
REQ-010 iSDRAM_Wr_Addr  input  24  client write address; iSDRAM_Wr_Data1..4 input 16 each, words for beats 0..3.
REQ-011 oSDRAM_Wr_Done  output  1  one-cycle write completion pulse.
REQ-012 oMem_Cmd_Valid / iMem_Cmd_Ready  out/in  1  burst command handshake to native SDRAM controller; oMem_Cmd_Wr out 1 (1=write); oMem_Addr out 24.
REQ-013 iMem_Wr_Data_Req  input  1  controller pulls one write word per asserted cycle; oMem_Wr_Data output 16.
REQ-014 iMem_Rd_Valid  input  1 / iMem_Rd_Data  input  16  one read beat per asserted cycle.
REQ-015 oAlign_Err  output  1  misaligned-address pulse (see Configuration).

Function
REQ-016 States SHALL be IDLE, CMD, WR_BEAT, RD_BEAT, DONE, RELEASE.
REQ-017 IDLE: on any Req high, latch address, direction, and (write) all four data words; go to CMD next cycle.
REQ-018 Both Reqs high in IDLE SHALL alternate by a last-served flag; flag resets to "read", so write wins first.
REQ-019 CMD: oMem_Cmd_Valid=1 with oMem_Addr, oMem_Cmd_Wr stable until cycle where iMem_Cmd_Ready=1; then Valid=0 next cycle and go to WR_BEAT or RD_BEAT.
REQ-020 WR_BEAT: oMem_Wr_Data SHALL present word[beat] combinationally from 2-bit beat counter; counter increments per iMem_Wr_Data_Req; after beat 3 accepted go to DONE.
REQ-021 RD_BEAT: each iMem_Rd_Valid stores iMem_Rd_Data into oSDRAM_Data[beat+1]; after beat 3 go to DONE.
REQ-022 DONE: assert exactly one Done pulse (Rd or Wr per direction) for one cycle; go to RELEASE.
REQ-023 RELEASE: remain until the served Req is low, then IDLE; a held Req SHALL NOT start a second transfer.
REQ-024 oSDRAM_Data1..4 SHALL be stable from the Done pulse until the next read's first beat is stored.
REQ-025 Beat strobes outside WR_BEAT/RD_BEAT SHALL be ignored; beat counter wraps 3->0 only on state exit.
REQ-026 Minimum latency: Req high to Done = 1 (IDLE) + 1 (CMD, Ready immediate) + 4 beats + 1 = 7 cycles.

Reset
REQ-027 Asserting rst_n low at any time, including mid-burst, SHALL force IDLE, beat counter 0, last-served flag "read", all outputs 0 (Cmd_Valid, Done pulses, oAlign_Err, oMem_Addr, oMem_Wr_Data, oSDRAM_Data1..4).
REQ-028 An interrupted burst SHALL NOT produce a Done pulse after reset release.

Configuration
REQ-029 Macro ZSDRAM_ALIGN_CHECK_EN defined: request with addr[1:0]!=0 SHALL skip CMD, pulse oAlign_Err and the matching Done in the same cycle, issue no memory command, read data unchanged.
REQ-030 Macro undefined: addr[1:0] SHALL be forced to 0 on oMem_Addr; oAlign_Err tied 0.

Structure
REQ-031 Shared package SHALL hold state encoding, BURST_LEN, ADDR_W, GRAM base 0, GRAM end 383999, pulse-counter ring-buffer base 384000 and last slot 386396.
REQ-032 One sub-module zsdram_beat_cnt (2-bit beat counter with last-beat flag) SHALL be used for both write and read beats.

Verification
REQ-033 Write addr 384000, data 0x1111/2222/3333/4444, Ready immediate, Wr_Data_Req 4 consecutive cycles -> oMem_Wr_Data sequence 1111,2222,3333,4444; Wr_Done pulse at cycle 7.
REQ-034 Read addr 386396, Rd_Valid beats 0x00C8,0,0,0 with 1-cycle gaps -> Data1=0x00C8, Data2..4=0, single Rd_Done after last beat.
REQ-035 Rd_Req and Wr_Req rise same cycle, both repeated -> order write, read, write, read.
REQ-036 Req held high 5 cycles after Done -> no second Cmd_Valid until Req dropped and re-raised.
REQ-037 rst_n low after beat 2 of a read -> all outputs 0, no Done after release; next read completes normally.
REQ-038 Address 7213 with ZSDRAM_ALIGN_CHECK_EN -> oAlign_Err+Done pulse, no Cmd_Valid; without macro -> oMem_Addr=7212.
